// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job sequencer: state encoding and default sizing.
package gcd_pkg;

  localparam int DEFAULT_W       = 16;
  localparam int DEFAULT_TIMEOUT = 4096;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_LOAD_B  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;
  localparam logic [2:0] ST_ENG_CLR = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    LOAD_A  = ST_LOAD_A,
    LOAD_B  = ST_LOAD_B,
    WAIT    = ST_WAIT,
    RESP    = ST_RESP,
    ENG_CLR = ST_ENG_CLR
  } state_t;

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Host-side operand/result handshake bundle of the GCD job sequencer.
import gcd_pkg::*;

interface gcd_job_sequencer_if #(parameter int W = DEFAULT_W) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_timeout;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_gcd, out_timeout
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_gcd, out_timeout
  );
endinterface

// File: rtl/gcd_timeout_counter.sv
// WAIT-phase cycle counter; expired is high while the count sits at TIMEOUT-1.
module gcd_timeout_counter #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      timer <= '0;
    else if (clear)  timer <= '0;
    else if (enable) timer <= timer + 1'b1;
  end

  assign expired = (timer == LAST);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds operand pairs into the serial-load GCD engine, returns its result and clears it after each job.
//   state   | meaning
//   IDLE    | ready for an operand pair
//   LOAD_A  | eng_start high, eng_data = A
//   LOAD_B  | eng_data = B, timer cleared
//   WAIT    | waiting for eng_done or timer expiry
//   RESP    | result held on out_* until accepted
//   ENG_CLR | engine held in reset for one cycle
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  gcd_job_sequencer_if.slave host,
  output logic            busy,
  output logic            eng_start,
  output logic [W-1:0]    eng_data,
  output logic            eng_rst_n,
  input  logic            eng_done,
  input  logic [W-1:0]    eng_result
);

  state_t       state, state_nxt;
  logic [W-1:0] a_q, a_nxt, b_q, b_nxt;
  logic [W-1:0] gcd_q, gcd_nxt, data_q, data_nxt;
  logic         valid_q, valid_nxt, tmo_q, tmo_nxt, start_q, start_nxt;
  logic         expired;
  logic         bypass;

  gcd_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == LOAD_B),
    .enable  (state == WAIT),
    .expired (expired)
  );

  // A zero operand would never let the engine terminate, so such jobs skip it.
  assign bypass = (a_q == '0) || (b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      gcd_q   <= gcd_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      tmo_q   <= tmo_nxt;
      start_q <= start_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    gcd_nxt   = gcd_q;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    tmo_nxt   = tmo_q;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        data_nxt = '0;
        if (host.in_valid) begin
          a_nxt = host.in_a;
          b_nxt = host.in_b;
          if ((host.in_a == '0) || (host.in_b == '0)) begin
            state_nxt = RESP;
            gcd_nxt   = host.in_a | host.in_b;
            tmo_nxt   = 1'b0;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = LOAD_A;
            start_nxt = 1'b1;
            data_nxt  = host.in_a;
          end
        end
      end
      LOAD_A: begin
        state_nxt = LOAD_B;
        data_nxt  = b_q;
      end
      LOAD_B: state_nxt = WAIT;
      WAIT: begin
        if (eng_done) begin
          state_nxt = RESP;
          gcd_nxt   = eng_result;
          tmo_nxt   = 1'b0;
          valid_nxt = 1'b1;
        end else if (expired) begin
          state_nxt = RESP;
          gcd_nxt   = '0;
          tmo_nxt   = 1'b1;
          valid_nxt = 1'b1;
        end
      end
      RESP: begin
        if (host.out_ready) begin
          valid_nxt = 1'b0;
          if (bypass) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = ENG_CLR;
            data_nxt  = '0;
          end
        end
      end
      ENG_CLR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign host.in_ready    = (state == IDLE);
  assign host.out_valid   = valid_q;
  assign host.out_gcd     = gcd_q;
  assign host.out_timeout = tmo_q;
  assign busy             = (state != IDLE);
  assign eng_start        = start_q;
  assign eng_data         = data_q;
  assign eng_rst_n        = rst_n & (state != ENG_CLR);

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench: behavioural subtractive GCD engine plus stubbed done/result modes.
module tb_gcd_job_sequencer;
  import gcd_pkg::*;

  localparam int W = 16;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, eng_start, eng_rst_n, eng_done;
  logic [W-1:0] eng_data, eng_result;

  gcd_job_sequencer_if #(.W(W)) host ();

  gcd_job_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host.slave),
    .busy       (busy),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_rst_n  (eng_rst_n),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  always #5 clk = ~clk;

  // Engine model: load A on start, B next cycle, subtract until equal, stick in done.
  typedef enum logic [1:0] {E_LOAD, E_LB, E_RUN, E_DONE} eng_st_t;
  eng_st_t e_st;
  logic [W-1:0] e_a, e_b;

  always_ff @(posedge clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      e_st <= E_LOAD; e_a <= '0; e_b <= '0;
    end else begin
      case (e_st)
        E_LOAD: if (eng_start) begin e_a <= eng_data; e_st <= E_LB; end
        E_LB:   begin e_b <= eng_data; e_st <= E_RUN; end
        E_RUN: begin
          if (e_a == e_b)     e_st <= E_DONE;
          else if (e_a > e_b) e_a <= e_a - e_b;
          else                e_b <= e_b - e_a;
        end
        default: e_st <= E_DONE;
      endcase
    end
  end

  // cnt = 0 in LOAD_B, k in the k-th WAIT cycle.
  int cnt = 0;
  int start_cnt = 0;
  int clr_cnt = 0;
  always_ff @(posedge clk) begin
    cnt <= eng_start ? 0 : cnt + 1;
    if (eng_start) start_cnt <= start_cnt + 1;
    if (rst_n && !eng_rst_n) clr_cnt <= clr_cnt + 1;
  end

  int mode = 0;  // 0 real engine, 1 done stuck low, 2 done forced at 16th WAIT cycle
  assign eng_done   = (mode == 0) ? (e_st == E_DONE) : (mode == 1) ? 1'b0 : (cnt == TIMEOUT);
  assign eng_result = (mode == 2) ? 16'h0abc : e_a;

  int total = 0;
  int bad = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [W:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && host.out_valid && host.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result actual=%0d required=none", host.out_gcd);
        end else begin
          e = exp_q.pop_front();
          check("result_gcd", 32'(host.out_gcd), 32'(e[W-1:0]));
          check("result_timeout", 32'(host.out_timeout), 32'(e[W]));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (!host.in_ready && n < 200) begin @(negedge clk); n++; end
    check(name, 32'(host.in_ready), 1);
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!host.out_valid && n < 200) begin @(negedge clk); n++; end
    check(name, 32'(host.out_valid), 1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle("idle_before_send");
    host.in_a = a; host.in_b = b; host.in_valid = 1'b1;
    @(negedge clk);
    host.in_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(host.in_ready), 1);
    check("rst_out_valid", 32'(host.out_valid), 0);
    check("rst_out_gcd", 32'(host.out_gcd), 0);
    check("rst_out_timeout", 32'(host.out_timeout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_eng_data", 32'(eng_data), 0);
    check("rst_eng_rst_n", 32'(eng_rst_n), 0);
  endtask

  initial begin : stim
    int s0, c0;
    host.in_valid = 1'b0; host.in_a = '0; host.in_b = '0; host.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // Engine path (143,78)
    s0 = start_cnt; c0 = clr_cnt;
    exp_q.push_back({1'b0, 16'd13});
    send(16'd143, 16'd78);
    check("load_a_start", 32'(eng_start), 1);
    check("load_a_data", 32'(eng_data), 143);
    @(negedge clk);
    check("load_b_start", 32'(eng_start), 0);
    check("load_b_data", 32'(eng_data), 78);
    wait_out("out_143_78");
    wait_idle("idle_143_78");
    check("start_pulses_143", 32'(start_cnt - s0), 1);
    check("clr_pulses_143", 32'(clr_cnt - c0), 1);

    // Zero-operand bypass
    s0 = start_cnt; c0 = clr_cnt;
    exp_q.push_back({1'b0, 16'd25});
    send(16'd0, 16'd25);
    check("bypass_latency_0_25", 32'(host.out_valid), 1);
    wait_idle("idle_0_25");
    exp_q.push_back({1'b0, 16'd0});
    send(16'd0, 16'd0);
    check("bypass_latency_0_0", 32'(host.out_valid), 1);
    wait_idle("idle_0_0");
    check("bypass_no_start", 32'(start_cnt - s0), 0);
    check("bypass_no_clr", 32'(clr_cnt - c0), 0);

    // Timeout with done stuck low
    mode = 1;
    exp_q.push_back({1'b1, 16'd0});
    send(16'd5, 16'd3);
    wait_out("out_timeout");
    check("timeout_wait_cycles", 32'(cnt), TIMEOUT + 1);
    wait_idle("idle_timeout");
    mode = 0;

    // Backpressure on (48,18) with a second job offered during the hold
    host.out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'd6});
    send(16'd48, 16'd18);
    wait_out("out_48_18");
    host.in_a = 16'd12; host.in_b = 16'd8; host.in_valid = 1'b1;
    exp_q.push_back({1'b0, 16'd4});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(host.out_valid), 1);
      check("hold_out_gcd", 32'(host.out_gcd), 6);
      check("hold_in_ready", 32'(host.in_ready), 0);
    end
    host.out_ready = 1'b1;
    @(negedge clk);
    check("clr_eng_rst_n", 32'(eng_rst_n), 0);
    check("clr_in_ready", 32'(host.in_ready), 0);
    @(negedge clk);
    check("after_clr_in_ready", 32'(host.in_ready), 1);
    @(negedge clk);
    host.in_valid = 1'b0;
    check("second_job_accepted", 32'(busy), 1);
    wait_out("out_12_8_held");
    wait_idle("idle_held");

    // Reset in the middle of WAIT on (1000,7)
    send(16'd1000, 16'd7);
    repeat (4) @(negedge clk);
    check("midjob_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({1'b0, 16'd4});
    send(16'd12, 16'd8);
    wait_out("out_12_8");
    wait_idle("idle_12_8");

    // done and timer expiry in the same cycle
    mode = 2;
    exp_q.push_back({1'b0, 16'h0abc});
    send(16'd9, 16'd4);
    wait_out("out_same_cycle");
    check("same_cycle_wait_cycles", 32'(cnt), TIMEOUT + 1);
    wait_idle("idle_same_cycle");
    mode = 0;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
